// File: rtl/ct_rst_seq.sv
// Core reset sequencer: synchronizes async reset release, then releases NUM_DOM domains in order.
// Optional per-domain soft reset holds are enabled by defining CT_RST_SEQ_SOFT_RST_EN.
module ct_rst_seq #(
  parameter int SYNC_DEPTH = 3,
  parameter int NUM_DOM    = 6,
  parameter int STAGE_GAP  = 2,
  parameter int SOFT_HOLD  = 4
) (
  input  logic               forever_coreclk,
  input  logic               async_corerst_b,
  input  logic               pad_yy_scan_mode,
  input  logic               pad_yy_scan_rst_b,
  input  logic [NUM_DOM-1:0] soft_rst_req,
  output logic [NUM_DOM-1:0] dom_rst_b,
  output logic               rst_seq_done,
  output logic               soft_rst_busy
);

  localparam int GAP_W = $clog2(STAGE_GAP + 1);
  localparam int IDX_W = $clog2(NUM_DOM + 1);
  localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(STAGE_GAP);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DOM - 1);

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [SYNC_DEPTH-1:0] sync_q;
  logic                 sync_rst_b;
  logic [GAP_W-1:0]     gap_cnt;
  logic [GAP_W-1:0]     gap_nxt;
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     idx_nxt;
  logic                 release_stb;
  logic                 done_q;
  logic                 done_nxt;
  logic [NUM_DOM-1:0]   rel_nxt;
  logic [NUM_DOM-1:0]   dom_q;
  logic [NUM_DOM-1:0]   dom_nxt;
  logic                 busy_int;

  // Release synchronizer: asserts asynchronously, releases after SYNC_DEPTH edges.
  always_ff @(posedge forever_coreclk or negedge async_corerst_b) begin
    if (!async_corerst_b) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], 1'b1};
    end
  end

  assign sync_rst_b = sync_q[SYNC_DEPTH-1];

  always_ff @(posedge forever_coreclk or negedge async_corerst_b) begin
    if (!async_corerst_b) begin
      state <= SYNC;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      SYNC: begin
        if (sync_rst_b) state_nxt = (NUM_DOM == 1) ? RUN : RELEASE;
      end
      RELEASE: begin
        if ((gap_cnt == GAP_MAX) && (idx == IDX_LAST)) state_nxt = RUN;
      end
      RUN:     state_nxt = RUN;
      default: state_nxt = SYNC;
    endcase
  end

  // Domain k is released once idx has moved past it; idx and gap_cnt freeze in RUN.
  always_comb begin
    gap_nxt     = gap_cnt;
    idx_nxt     = idx;
    done_nxt    = done_q;
    release_stb = 1'b0;
    unique case (state)
      SYNC: begin
        if (sync_rst_b) release_stb = 1'b1;
      end
      RELEASE: begin
        if (gap_cnt == GAP_MAX) release_stb = 1'b1;
        else                    gap_nxt = gap_cnt + GAP_W'(1);
      end
      default: ;
    endcase
    if (release_stb) begin
      gap_nxt = GAP_W'(1);
      idx_nxt = idx + IDX_W'(1);
      if (idx == IDX_LAST) done_nxt = 1'b1;
    end
    for (int k = 0; k < NUM_DOM; k++) begin
      rel_nxt[k] = (IDX_W'(k) < idx_nxt);
    end
  end

  always_ff @(posedge forever_coreclk or negedge async_corerst_b) begin
    if (!async_corerst_b) begin
      gap_cnt <= '0;
      idx     <= '0;
      done_q  <= 1'b0;
      dom_q   <= '0;
    end else begin
      gap_cnt <= gap_nxt;
      idx     <= idx_nxt;
      done_q  <= done_nxt;
      dom_q   <= dom_nxt;
    end
  end

`ifdef CT_RST_SEQ_SOFT_RST_EN
  localparam int HOLD_W = $clog2(SOFT_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(SOFT_HOLD);

  logic [NUM_DOM-1:0][HOLD_W-1:0] hold_cnt;
  logic [NUM_DOM-1:0][HOLD_W-1:0] hold_nxt;

  // A count of 1 means the hold ends this edge, so a fresh request may restart it.
  always_comb begin
    for (int k = 0; k < NUM_DOM; k++) begin
      hold_nxt[k] = hold_cnt[k];
      if ((state == RUN) && soft_rst_req[k] && (hold_cnt[k] <= HOLD_W'(1))) begin
        hold_nxt[k] = HOLD_MAX;
      end else if (hold_cnt[k] != '0) begin
        hold_nxt[k] = hold_cnt[k] - HOLD_W'(1);
      end
      dom_nxt[k] = rel_nxt[k] && (hold_nxt[k] == '0);
    end
  end

  always_ff @(posedge forever_coreclk or negedge async_corerst_b) begin
    if (!async_corerst_b) begin
      hold_cnt <= '0;
    end else begin
      hold_cnt <= hold_nxt;
    end
  end

  always_comb begin
    busy_int = 1'b0;
    for (int k = 0; k < NUM_DOM; k++) begin
      if (hold_cnt[k] != '0) busy_int = 1'b1;
    end
  end
`else
  localparam int unused_soft_hold = SOFT_HOLD;
  logic unused_req;

  assign unused_req = ^soft_rst_req;
  assign dom_nxt    = rel_nxt;
  assign busy_int   = 1'b0;
`endif

  // Scan mode bypasses the sequencer entirely.
  assign dom_rst_b     = pad_yy_scan_mode ? {NUM_DOM{pad_yy_scan_rst_b}} : dom_q;
  assign rst_seq_done  = pad_yy_scan_mode ? pad_yy_scan_rst_b : done_q;
  assign soft_rst_busy = pad_yy_scan_mode ? 1'b0 : busy_int;

endmodule

// File: tb/tb_ct_rst_seq.sv
// Bench for ct_rst_seq: default instance plus a minimal NUM_DOM=1/STAGE_GAP=1/SYNC_DEPTH=2 instance.
module tb_ct_rst_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_b;
  logic       scan_mode;
  logic       scan_rst_b;
  logic [5:0] req1;
  logic [5:0] dom1;
  logic       done1;
  logic       busy1;
  logic [0:0] req2;
  logic [0:0] dom2;
  logic       done2;
  logic       busy2;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [5:0] dom;
    logic       done;
    logic       busy;
    logic       dom2;
    logic       done2;
  } exp_t;

  exp_t sbq[$];

  ct_rst_seq dut (
    .forever_coreclk  (clk),
    .async_corerst_b  (rst_b),
    .pad_yy_scan_mode (scan_mode),
    .pad_yy_scan_rst_b(scan_rst_b),
    .soft_rst_req     (req1),
    .dom_rst_b        (dom1),
    .rst_seq_done     (done1),
    .soft_rst_busy    (busy1)
  );

  ct_rst_seq #(
    .SYNC_DEPTH(2),
    .NUM_DOM   (1),
    .STAGE_GAP (1),
    .SOFT_HOLD (4)
  ) dut2 (
    .forever_coreclk  (clk),
    .async_corerst_b  (rst_b),
    .pad_yy_scan_mode (scan_mode),
    .pad_yy_scan_rst_b(scan_rst_b),
    .soft_rst_req     (req2),
    .dom_rst_b        (dom2),
    .rst_seq_done     (done2),
    .soft_rst_busy    (busy2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    chk({tag, " dom"},   32'(dom1),  32'(e.dom));
    chk({tag, " done"},  32'(done1), 32'(e.done));
    chk({tag, " busy"},  32'(busy1), 32'(e.busy));
    chk({tag, " dom2"},  32'(dom2),  32'(e.dom2));
    chk({tag, " done2"}, 32'(done2), 32'(e.done2));
    chk({tag, " busy2"}, 32'(busy2), 32'(1'b0));
  endtask

  task automatic check_pop(input string tag);
    exp_t e;
    checks++;
    assert (sbq.size() != 0) else begin
      failures++;
      $error("FAIL %s scoreboard observed=empty expected=entry", tag);
    end
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      check_all(tag, e);
    end
  endtask

  function automatic exp_t seq_exp(input int n);
    exp_t e;
    for (int k = 0; k < 6; k++) e.dom[k] = (n >= 4 + 2 * k);
    e.done  = (n >= 14);
    e.busy  = 1'b0;
    e.dom2  = (n >= 3);
    e.done2 = (n >= 3);
    return e;
  endfunction

  // Edge 0 is the first edge seen with reset low; release follows 2ns later.
  // Soft requests are held high during start-up to show they are ignored there.
  task automatic run_seq(input int last);
    @(posedge clk);
    #2 rst_b = 1'b1;
    for (int n = 1; n <= last; n++) begin
      req1 = (n <= 13) ? 6'h3F : 6'h00;
      req2 = (n <= 3) ? 1'b1 : 1'b0;
      sbq.push_back(seq_exp(n));
      @(posedge clk);
      #1;
      check_pop($sformatf("seq_edge%0d", n));
    end
    req1 = '0;
    req2 = '0;
  endtask

  logic [5:0] sr_tbl  [0:10] = '{6'h05, 6'h00, 6'h01, 6'h00, 6'h01, 6'h00,
                                 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
`ifdef CT_RST_SEQ_SOFT_RST_EN
  logic [5:0] sr_dom  [0:10] = '{6'h3A, 6'h3A, 6'h3A, 6'h3A, 6'h3E, 6'h3E,
                                 6'h3E, 6'h3E, 6'h3F, 6'h3F, 6'h3F};
  logic       sr_busy [0:10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
`else
  logic [5:0] sr_dom  [0:10] = '{6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F,
                                 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F};
  logic       sr_busy [0:10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif

  initial begin
    exp_t e;
    rst_b      = 1'b0;
    scan_mode  = 1'b0;
    scan_rst_b = 1'b0;
    req1       = '0;
    req2       = '0;
    repeat (3) @(posedge clk);
    #1;
    e = '{dom: 6'h00, done: 1'b0, busy: 1'b0, dom2: 1'b0, done2: 1'b0};
    check_all("reset_state", e);

    // Scan override while the functional logic is held in reset.
    scan_mode  = 1'b1;
    scan_rst_b = 1'b1;
    #1;
    e = '{dom: 6'h3F, done: 1'b1, busy: 1'b0, dom2: 1'b1, done2: 1'b1};
    check_all("scan_in_reset_hi", e);
    scan_mode  = 1'b0;
    scan_rst_b = 1'b0;

    // Abort the sequence at edge 9 and restart it.
    run_seq(9);
    rst_b = 1'b0;
    #1;
    e = '{dom: 6'h00, done: 1'b0, busy: 1'b0, dom2: 1'b0, done2: 1'b0};
    check_all("abort_async", e);
    run_seq(16);

    // Soft reset: two domains at once, a re-request inside the hold, a restart at release.
    for (int j = 0; j <= 10; j++) begin
      req1 = sr_tbl[j];
      sbq.push_back('{dom: sr_dom[j], done: 1'b1, busy: sr_busy[j], dom2: 1'b1, done2: 1'b1});
      @(posedge clk);
      #1;
      check_pop($sformatf("soft_E+%0d", j));
    end
    req1 = '0;

    // Scan override in RUN, toggled between clock edges.
    scan_mode  = 1'b1;
    scan_rst_b = 1'b0;
    #1;
    e = '{dom: 6'h00, done: 1'b0, busy: 1'b0, dom2: 1'b0, done2: 1'b0};
    check_all("scan_run_lo0", e);
    scan_rst_b = 1'b1;
    #1;
    e = '{dom: 6'h3F, done: 1'b1, busy: 1'b0, dom2: 1'b1, done2: 1'b1};
    check_all("scan_run_hi", e);
    scan_rst_b = 1'b0;
    #1;
    e = '{dom: 6'h00, done: 1'b0, busy: 1'b0, dom2: 1'b0, done2: 1'b0};
    check_all("scan_run_lo1", e);
    scan_mode = 1'b0;
    #1;
    e = '{dom: 6'h3F, done: 1'b1, busy: 1'b0, dom2: 1'b1, done2: 1'b1};
    check_all("scan_exit", e);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
